// File: rtl/stream_pkg.sv
// Shared constants and helpers for the stream multiplexer and its arbiter.
package stream_pkg;

   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;

   // Index width that never collapses to zero bits for tiny channel counts.
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: round-robin search from a pointer, or fixed lowest-index priority.
module rr_arbiter
   import stream_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int MODE   = MODE_RR,
   localparam int CH_W   = clog2_safe(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   input  logic              en,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   grant_idx
);

   always_comb begin
      logic            found;
      int              start;
      int              c;
      logic [CH_W-1:0] cidx;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      c         = 0;
      cidx      = '0;
      start     = (MODE == MODE_FIXED) ? 0 : int'(ptr);
      // Walk every channel once, starting at the pointer and wrapping past NUM_CH-1.
      for (int k = 0; k < NUM_CH; k++) begin
         c = start + k;
         if (c >= NUM_CH) c = c - NUM_CH;
         cidx = CH_W'(c);
         if (en && !found && req[cidx]) begin
            found       = 1'b1;
            grant[cidx] = 1'b1;
            grant_idx   = cidx;
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux with packet locking and a single registered output stage.
module stream_mux_rr
   import stream_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int DATA_W = 8,
   parameter  int MODE   = MODE_RR,
   localparam int CH_W   = clog2_safe(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_chan,
   output logic                     out_last
);

   logic              load_en;
   logic              accept;
   logic              lock;
   logic [CH_W-1:0]   lock_chan;
   logic [CH_W-1:0]   ptr;
   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] grant;
   logic [CH_W-1:0]   grant_idx;
   logic [DATA_W-1:0] sel_data;
   logic              sel_last;

   assign load_en = !out_valid || out_ready;

   // While a packet is open only its channel may request; everyone else stalls.
   assign req = lock ? (in_valid & (NUM_CH'(1) << lock_chan)) : in_valid;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .MODE   (MODE)
   ) u_arb (
      .req       (req),
      .ptr       (ptr),
      .en        (load_en),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign in_ready = grant;
   assign accept   = |grant;

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) begin
            sel_data = in_data[i*DATA_W +: DATA_W];
            sel_last = in_last[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         out_last  <= 1'b0;
         lock      <= 1'b0;
         lock_chan <= '0;
         ptr       <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_chan  <= grant_idx;
            out_last  <= sel_last;
            lock      <= !sel_last;
            if (!sel_last) lock_chan <= grant_idx;
            // Fairness advances only at packet boundaries.
            if (MODE == MODE_RR && sel_last)
               ptr <= (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + CH_W'(1);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: round-robin and fixed-priority instances share stimulus; reference model plus scoreboard.
module tb_stream_mux_rr;

   localparam int N = 4;
   localparam int W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     in_valid;
   logic [N-1:0]     in_last;
   logic [N*W-1:0]   in_data;
   logic             out_ready;

   logic [N-1:0]     rdy_rr, rdy_fp;
   logic             ov_rr, ov_fp, ol_rr, ol_fp;
   logic [W-1:0]     od_rr, od_fp;
   logic [1:0]       oc_rr, oc_fp;

   always #5 clk = ~clk;

   stream_mux_rr #(.NUM_CH(N), .DATA_W(W), .MODE(0)) dut_rr (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_rr),
      .in_data(in_data), .in_last(in_last), .out_valid(ov_rr), .out_ready(out_ready),
      .out_data(od_rr), .out_chan(oc_rr), .out_last(ol_rr));

   stream_mux_rr #(.NUM_CH(N), .DATA_W(W), .MODE(1)) dut_fp (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_fp),
      .in_data(in_data), .in_last(in_last), .out_valid(ov_fp), .out_ready(out_ready),
      .out_data(od_fp), .out_chan(oc_fp), .out_last(ol_fp));

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [7:0] d;
      int         c;
      logic       l;
   } beat_t;

   beat_t q_rr[$];
   beat_t q_fp[$];

   // Reference model state, index 0 = round-robin instance, 1 = fixed priority.
   logic       m_ov[2];
   logic       m_lock[2];
   int         m_lc[2];
   int         m_ptr[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ov[k]   = 1'b0;
         m_lock[k] = 1'b0;
         m_lc[k]   = 0;
         m_ptr[k]  = 0;
      end
      q_rr.delete();
      q_fp.delete();
   endtask

   function automatic int model_grant(input int k, input logic [N-1:0] v, input logic rdy);
      int start;
      if (m_ov[k] && !rdy) return -1;
      if (m_lock[k]) return v[m_lc[k]] ? m_lc[k] : -1;
      start = (k == 1) ? 0 : m_ptr[k];
      for (int j = 0; j < N; j++) begin
         if (v[(start + j) % N]) return (start + j) % N;
      end
      return -1;
   endfunction

   // One clock: check combinational/output state before the edge, then advance the model.
   task automatic cycle();
      int    g[2];
      beat_t b;
      beat_t e;
      logic [N-1:0] exp_rdy;
      logic         ov;
      #1;
      for (int k = 0; k < 2; k++) begin
         g[k]    = model_grant(k, in_valid, out_ready);
         exp_rdy = (g[k] >= 0) ? N'(1 << g[k]) : '0;
         ov      = (k == 0) ? ov_rr : ov_fp;
         chk(k == 0 ? "rr_in_ready" : "fp_in_ready", 32'(k == 0 ? rdy_rr : rdy_fp), 32'(exp_rdy));
         chk(k == 0 ? "rr_out_valid" : "fp_out_valid", 32'(ov), 32'(m_ov[k]));
         if (ov && out_ready) begin
            if ((k == 0 ? q_rr.size() : q_fp.size()) == 0) begin
               chk(k == 0 ? "rr_unexpected_beat" : "fp_unexpected_beat", 32'(1), 32'(0));
            end else begin
               e = (k == 0) ? q_rr.pop_front() : q_fp.pop_front();
               chk(k == 0 ? "rr_sb_data" : "fp_sb_data", 32'(k == 0 ? od_rr : od_fp), 32'(e.d));
               chk(k == 0 ? "rr_sb_chan" : "fp_sb_chan", 32'(k == 0 ? oc_rr : oc_fp), 32'(e.c));
               chk(k == 0 ? "rr_sb_last" : "fp_sb_last", 32'(k == 0 ? ol_rr : ol_fp), 32'(e.l));
            end
         end
         if (g[k] >= 0) begin
            b.d = in_data[g[k]*W +: W];
            b.c = g[k];
            b.l = in_last[g[k]];
            if (k == 0) q_rr.push_back(b); else q_fp.push_back(b);
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (g[k] >= 0) begin
            m_ov[k]   = 1'b1;
            m_lock[k] = !in_last[g[k]];
            if (!in_last[g[k]]) m_lc[k] = g[k];
            if (in_last[g[k]] && k == 0) m_ptr[k] = (g[k] + 1) % N;
         end else if (out_ready) begin
            m_ov[k] = 1'b0;
         end
      end
      #1;
   endtask

   typedef struct {
      logic [N-1:0] v;
      logic [N-1:0] l;
      logic         rdy;
      logic [31:0]  d;
      logic [N-1:0] e_rdy;
      logic         e_ov;
      logic [1:0]   e_ch;
      logic [7:0]   e_d;
   } vec_t;

   vec_t tbl[16];

   initial begin
      tbl[0]  = '{4'hF, 4'hF, 1'b1, 32'hA3A2A1A0, 4'b0001, 1'b1, 2'd0, 8'hA0};
      tbl[1]  = '{4'hF, 4'hF, 1'b1, 32'hA3A2A1A0, 4'b0010, 1'b1, 2'd1, 8'hA1};
      tbl[2]  = '{4'hF, 4'hF, 1'b1, 32'hA3A2A1A0, 4'b0100, 1'b1, 2'd2, 8'hA2};
      tbl[3]  = '{4'hF, 4'hF, 1'b1, 32'hA3A2A1A0, 4'b1000, 1'b1, 2'd3, 8'hA3};
      tbl[4]  = '{4'hF, 4'hF, 1'b1, 32'hA3A2A1A0, 4'b0001, 1'b1, 2'd0, 8'hA0};
      tbl[5]  = '{4'b0110, 4'b0100, 1'b1, 32'h00221100, 4'b0010, 1'b1, 2'd1, 8'h11};
      tbl[6]  = '{4'b0110, 4'b0100, 1'b1, 32'h00221200, 4'b0010, 1'b1, 2'd1, 8'h12};
      tbl[7]  = '{4'b0110, 4'b0110, 1'b1, 32'h00221300, 4'b0010, 1'b1, 2'd1, 8'h13};
      tbl[8]  = '{4'b0100, 4'b0100, 1'b1, 32'h00220000, 4'b0100, 1'b1, 2'd2, 8'h22};
      tbl[9]  = '{4'b0001, 4'b0001, 1'b1, 32'h0000005A, 4'b0001, 1'b1, 2'd0, 8'h5A};
      for (int i = 10; i < 15; i++)
         tbl[i] = '{4'b0001, 4'b0001, 1'b0, 32'h0000005B, 4'b0000, 1'b1, 2'd0, 8'h5A};
      tbl[15] = '{4'b0000, 4'b0000, 1'b1, 32'h00000000, 4'b0000, 1'b0, 2'd0, 8'h5A};

      in_valid  = '0;
      in_last   = '0;
      in_data   = '0;
      out_ready = 1'b1;
      model_reset();

      // Reset values while held in reset, then idle for 10 cycles.
      #12;
      chk("reset_out_valid", 32'(ov_rr), 32'(0));
      chk("reset_out_data",  32'(od_rr), 32'(0));
      chk("reset_out_chan",  32'(oc_rr), 32'(0));
      chk("reset_out_last",  32'(ol_rr), 32'(0));
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("idle_out_valid", 32'(ov_rr), 32'(0));
         chk("idle_out_chan",  32'(oc_rr), 32'(0));
         chk("idle_in_ready",  32'(rdy_rr), 32'(0));
      end

      // Fairness, packet lock, backpressure (round-robin instance, hand-derived).
      for (int i = 0; i < 16; i++) begin
         in_valid  = tbl[i].v;
         in_last   = tbl[i].l;
         in_data   = tbl[i].d;
         out_ready = tbl[i].rdy;
         #1;
         chk($sformatf("tbl%0d_in_ready", i), 32'(rdy_rr), 32'(tbl[i].e_rdy));
         cycle();
         chk($sformatf("tbl%0d_out_valid", i), 32'(ov_rr), 32'(tbl[i].e_ov));
         if (tbl[i].e_ov) begin
            chk($sformatf("tbl%0d_out_chan", i), 32'(oc_rr), 32'(tbl[i].e_ch));
            chk($sformatf("tbl%0d_out_data", i), 32'(od_rr), 32'(tbl[i].e_d));
         end
      end

      // Fixed priority: ch0 always beats ch3 until ch0 drops valid.
      in_valid  = 4'b1001;
      in_last   = 4'b1001;
      in_data   = 32'h3300000A;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("fp_prio_in_ready", 32'(rdy_fp), 32'(4'b0001));
         cycle();
         chk("fp_prio_out_chan", 32'(oc_fp), 32'(0));
      end
      in_valid = 4'b1000;
      #1;
      chk("fp_ch3_in_ready", 32'(rdy_fp), 32'(4'b1000));
      cycle();
      chk("fp_ch3_out_chan", 32'(oc_fp), 32'(3));
      chk("fp_ch3_out_data", 32'(od_fp), 32'(8'h33));

      // Async reset between beats of a ch2 packet.
      in_valid = 4'b0100;
      in_last  = 4'b0000;
      in_data  = 32'h00310000;
      cycle();
      chk("pkt2_out_chan", 32'(oc_rr), 32'(2));
      chk("pkt2_out_valid", 32'(ov_rr), 32'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(ov_rr), 32'(0));
      chk("async_rst_out_data",  32'(od_rr), 32'(0));
      chk("async_rst_out_chan",  32'(oc_rr), 32'(0));
      chk("async_rst_out_last",  32'(ol_rr), 32'(0));
      chk("async_rst_fp_valid",  32'(ov_fp), 32'(0));
      model_reset();
      #1;
      rst_n    = 1'b1;
      in_valid = 4'b0101;
      in_last  = 4'b0101;
      in_data  = 32'h00320040;
      #1;
      chk("post_rst_in_ready", 32'(rdy_rr), 32'(4'b0001));
      cycle();
      chk("post_rst_out_chan", 32'(oc_rr), 32'(0));
      chk("post_rst_out_data", 32'(od_rr), 32'(8'h40));

      // Drain and make sure every predicted beat was delivered.
      in_valid = '0;
      in_last  = '0;
      for (int i = 0; i < 3; i++) cycle();
      chk("rr_sb_empty", 32'(q_rr.size()), 32'(0));
      chk("fp_sb_empty", 32'(q_fp.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
